// File: rtl/motor_drive_if.sv
// Command and gate-drive bundle between motor_fsm (master) and the H-bridge
// driver (slave). The master issues the motor_up/motor_dn levels; the slave
// returns the four gate signals plus status.
interface motor_drive_if #(
  parameter int PWM_BITS = 3
);
  logic              motor_up;
  logic              motor_dn;
  logic              hs_a;
  logic              ls_a;
  logic              hs_b;
  logic              ls_b;
  logic              running;
  logic [PWM_BITS:0] duty;
  logic              cmd_err;

  modport master (
    output motor_up, motor_dn,
    input  hs_a, ls_a, hs_b, ls_b, running, duty, cmd_err
  );

  modport slave (
    input  motor_up, motor_dn,
    output hs_a, ls_a, hs_b, ls_b, running, duty, cmd_err
  );
endinterface

// File: rtl/motor_drive.sv
// H-bridge gate driver for the door motor. Soft-starts each run with a PWM
// duty ramp, holds all gates off for a dead time after every stop or
// reversal, and flags conflicting up/dn commands. All outputs are registered.
module motor_drive #(
  parameter int DEAD_CYC = 4,
  parameter int PWM_BITS = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  motor_drive_if.slave drv
);

  localparam logic [PWM_BITS:0]   DUTY_FULL = (PWM_BITS+1)'(1 << PWM_BITS);
  localparam logic [PWM_BITS:0]   DUTY_ONE  = (PWM_BITS+1)'(1);
  localparam logic [PWM_BITS-1:0] CNT_MAX   = '1;
  localparam logic [7:0]          DEAD_LOAD = 8'(DEAD_CYC);

  typedef enum logic [1:0] {IDLE, RAMP, RUN, DEAD} state_t;

  state_t              state;
  logic                dir;       // 0 = up, 1 = dn
  logic [PWM_BITS-1:0] cnt;
  logic [PWM_BITS:0]   duty_r;
  logic [7:0]          dead_cnt;

  logic                conflict;
  logic                stop;
  logic [PWM_BITS-1:0] cnt_nx;
  logic [PWM_BITS:0]   duty_nx;
  logic                pwm_nx;

  // Stop detection and next PWM step, so gates reflect the post-edge cnt/duty.
  always_comb begin
    conflict = drv.motor_up & drv.motor_dn;
    stop     = 1'b0;
    cnt_nx   = cnt + 1'b1;
    duty_nx  = duty_r;
    if (dir) stop = !drv.motor_dn || drv.motor_up;
    else     stop = !drv.motor_up || drv.motor_dn;
    if (cnt == CNT_MAX) duty_nx = duty_r + DUTY_ONE;
    pwm_nx = ({1'b0, cnt_nx} < duty_nx);
  end

  // Drive FSM: IDLE -> RAMP -> RUN, any stop -> DEAD -> IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      dir         <= 1'b0;
      cnt         <= '0;
      duty_r      <= '0;
      dead_cnt    <= '0;
      drv.hs_a    <= 1'b0;
      drv.ls_a    <= 1'b0;
      drv.hs_b    <= 1'b0;
      drv.ls_b    <= 1'b0;
      drv.running <= 1'b0;
      drv.cmd_err <= 1'b0;
    end else begin
      drv.cmd_err <= 1'b0;
      case (state)
        IDLE: begin
          drv.hs_a    <= 1'b0;
          drv.ls_a    <= 1'b0;
          drv.hs_b    <= 1'b0;
          drv.ls_b    <= 1'b0;
          drv.running <= 1'b0;
          if (conflict) begin
            drv.cmd_err <= 1'b1;
          end else if (drv.motor_up || drv.motor_dn) begin
            // First RAMP cycle has cnt=0 < duty=1, so the high side is on.
            state    <= RAMP;
            dir      <= drv.motor_dn;
            cnt      <= '0;
            duty_r   <= DUTY_ONE;
            drv.hs_a <= drv.motor_up;
            drv.ls_b <= drv.motor_up;
            drv.hs_b <= drv.motor_dn;
            drv.ls_a <= drv.motor_dn;
          end
        end
        RAMP, RUN: begin
          if (stop) begin
            state       <= DEAD;
            dead_cnt    <= DEAD_LOAD;
            cnt         <= '0;
            duty_r      <= '0;
            drv.hs_a    <= 1'b0;
            drv.ls_a    <= 1'b0;
            drv.hs_b    <= 1'b0;
            drv.ls_b    <= 1'b0;
            drv.running <= 1'b0;
            drv.cmd_err <= conflict;
          end else if (state == RAMP) begin
            cnt    <= cnt_nx;
            duty_r <= duty_nx;
            if (duty_nx == DUTY_FULL) begin
              state       <= RUN;
              drv.running <= 1'b1;
              drv.hs_a    <= !dir;
              drv.hs_b    <= dir;
            end else begin
              drv.hs_a <= !dir & pwm_nx;
              drv.hs_b <= dir & pwm_nx;
            end
            drv.ls_b <= !dir;
            drv.ls_a <= dir;
          end
        end
        DEAD: begin
          drv.hs_a    <= 1'b0;
          drv.ls_a    <= 1'b0;
          drv.hs_b    <= 1'b0;
          drv.ls_b    <= 1'b0;
          drv.running <= 1'b0;
          if (dead_cnt == 8'd1) state <= IDLE;
          else                  dead_cnt <= dead_cnt - 8'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign drv.duty = duty_r;

endmodule

// File: tb/tb_motor_drive.sv
// Self-checking bench for motor_drive: directed scenarios plus a randomised
// command soak, all compared against a cycle-level behavioural model.
module tb_motor_drive;

  localparam int DC   = 4;
  localparam int PB   = 3;
  localparam int FULL = 1 << PB;
  localparam int VW   = PB + 7;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  motor_drive_if #(.PWM_BITS(PB)) bus ();

  motor_drive #(.DEAD_CYC(DC), .PWM_BITS(PB)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .drv  (bus)
  );

  always #5 clk = ~clk;

  wire [VW-1:0] dut_vec = {bus.hs_a, bus.ls_a, bus.hs_b, bus.ls_b,
                           bus.running, bus.duty, bus.cmd_err};
  wire          any_gate = bus.hs_a | bus.ls_a | bus.hs_b | bus.ls_b;

  // Reference model: mode 0 idle, 1 ramp, 2 run, 3 dead; m_t = cycles spent in ramp.
  int m_mode = 0;
  bit m_dir  = 1'b0;
  int m_t    = 0;
  int m_dead = 0;
  bit m_err  = 1'b0;

  // Reference model update, one step per clock.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode <= 0;
      m_dir  <= 1'b0;
      m_t    <= 0;
      m_dead <= 0;
      m_err  <= 1'b0;
    end else begin
      m_err <= 1'b0;
      case (m_mode)
        0: begin
          if (bus.motor_up && bus.motor_dn) m_err <= 1'b1;
          else if (bus.motor_up || bus.motor_dn) begin
            m_mode <= 1;
            m_dir  <= bus.motor_dn;
            m_t    <= 0;
          end
        end
        1, 2: begin
          if (!((m_dir ? bus.motor_dn : bus.motor_up) && !(m_dir ? bus.motor_up : bus.motor_dn))) begin
            m_err  <= bus.motor_up && bus.motor_dn;
            m_mode <= 3;
            m_dead <= DC;
          end else if (m_mode == 1) begin
            m_t <= m_t + 1;
            if (m_t == FULL * (FULL - 1) - 1) m_mode <= 2;
          end
        end
        default: begin
          m_dead <= m_dead - 1;
          if (m_dead == 1) m_mode <= 0;
        end
      endcase
    end
  end

  function automatic logic [VW-1:0] exp_vec();
    int d;
    bit hs, ls;
    logic [PB:0] dv;
    d = 0; hs = 1'b0; ls = 1'b0;
    if (m_mode == 1) begin
      d  = 1 + m_t / FULL;
      hs = ((m_t % FULL) < d);
      ls = 1'b1;
    end else if (m_mode == 2) begin
      d  = FULL;
      hs = 1'b1;
      ls = 1'b1;
    end
    dv = d[PB:0];
    return {hs & !m_dir, ls & m_dir, hs & m_dir, ls & !m_dir, (m_mode == 2), dv, m_err};
  endfunction

  task automatic go_idle();
    bus.motor_up = 1'b0;
    bus.motor_dn = 1'b0;
    repeat (DC + 3) @(negedge clk);
  endtask

  task automatic test_reset();
    bus.motor_up = 1'b0;
    bus.motor_dn = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if (dut_vec !== '0) begin
      n_fail++;
      $display("FAIL reset_async: got %b expected %b", dut_vec, {VW{1'b0}});
    end
    repeat (2) @(negedge clk);
    n_checks++;
    if (dut_vec !== exp_vec()) begin
      n_fail++;
      $display("FAIL reset_held: got %b expected %b", dut_vec, exp_vec());
    end
    rst_n = 1'b1;
  endtask

  task automatic test_up_run();
    int hs_cnt = 0;
    @(negedge clk);
    bus.motor_up = 1'b1;
    for (int i = 0; i < FULL * (FULL - 1); i++) begin
      @(negedge clk);
      n_checks++;
      if (dut_vec !== exp_vec()) begin
        n_fail++;
        $display("FAIL up_ramp_model cyc %0d: got %b expected %b", i, dut_vec, exp_vec());
      end
      n_checks++;
      if (bus.ls_b !== 1'b1 || bus.hs_b !== 1'b0 || bus.ls_a !== 1'b0 || bus.running !== 1'b0) begin
        n_fail++;
        $display("FAIL up_ramp_legs cyc %0d: got ls_b=%b hs_b=%b ls_a=%b running=%b expected 1 0 0 0",
                 i, bus.ls_b, bus.hs_b, bus.ls_a, bus.running);
      end
      if (bus.hs_a === 1'b1) hs_cnt++;
    end
    n_checks++;
    if (hs_cnt != FULL * (FULL - 1) / 2) begin
      n_fail++;
      $display("FAIL up_ramp_hs_count: got %0d expected %0d", hs_cnt, FULL * (FULL - 1) / 2);
    end
    @(negedge clk);
    n_checks++;
    if (bus.running !== 1'b1 || bus.hs_a !== 1'b1 || bus.ls_b !== 1'b1 ||
        bus.hs_b !== 1'b0 || bus.ls_a !== 1'b0 || bus.duty !== (PB+1)'(FULL)) begin
      n_fail++;
      $display("FAIL up_run: got run=%b hs_a=%b ls_b=%b hs_b=%b ls_a=%b duty=%0d expected 1 1 1 0 0 %0d",
               bus.running, bus.hs_a, bus.ls_b, bus.hs_b, bus.ls_a, bus.duty, FULL);
    end
  endtask

  task automatic test_stop();
    int gap = 1;
    bit found = 1'b0;
    bus.motor_up = 1'b0;
    @(negedge clk);
    n_checks++;
    if (any_gate !== 1'b0 || bus.duty !== '0 || bus.running !== 1'b0) begin
      n_fail++;
      $display("FAIL stop_off: got gates=%b duty=%0d running=%b expected 0 0 0",
               any_gate, bus.duty, bus.running);
    end
    bus.motor_up = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n_checks++;
      if (dut_vec !== exp_vec()) begin
        n_fail++;
        $display("FAIL stop_model: got %b expected %b", dut_vec, exp_vec());
      end
      if (bus.hs_a === 1'b1) begin
        found = 1'b1;
        break;
      end
      gap++;
    end
    n_checks++;
    if (!found || gap != DC + 1 || bus.duty !== (PB+1)'(1)) begin
      n_fail++;
      $display("FAIL stop_dead_len: got gap=%0d found=%0d duty=%0d expected gap=%0d found=1 duty=1",
               gap, found, bus.duty, DC + 1);
    end
    go_idle();
  endtask

  task automatic test_reversal();
    int gap = 0;
    @(negedge clk);
    bus.motor_up = 1'b1;
    repeat (12) @(negedge clk);
    bus.motor_up = 1'b0;
    bus.motor_dn = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.hs_b === 1'b1) break;
      n_checks++;
      if (any_gate !== 1'b0) begin
        n_fail++;
        $display("FAIL rev_gap_gate: got gates=%b%b%b%b expected 0000",
                 bus.hs_a, bus.ls_a, bus.hs_b, bus.ls_b);
      end
      gap++;
    end
    n_checks++;
    if (gap != DC + 1 || bus.hs_b !== 1'b1 || bus.ls_a !== 1'b1 || bus.hs_a !== 1'b0 ||
        bus.ls_b !== 1'b0 || bus.duty !== (PB+1)'(1)) begin
      n_fail++;
      $display("FAIL rev_start: got gap=%0d hs_b=%b ls_a=%b hs_a=%b ls_b=%b duty=%0d expected %0d 1 1 0 0 1",
               gap, bus.hs_b, bus.ls_a, bus.hs_a, bus.ls_b, bus.duty, DC + 1);
    end
    go_idle();
  endtask

  task automatic test_conflict();
    int waited = 0;
    @(negedge clk);
    bus.motor_up = 1'b1;
    bus.motor_dn = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.cmd_err !== 1'b1 || any_gate !== 1'b0) begin
      n_fail++;
      $display("FAIL conflict_idle_err: got err=%b gates=%b expected 1 0", bus.cmd_err, any_gate);
    end
    bus.motor_up = 1'b0;
    bus.motor_dn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (bus.cmd_err !== 1'b0 || any_gate !== 1'b0) begin
        n_fail++;
        $display("FAIL conflict_idle_after: got err=%b gates=%b expected 0 0", bus.cmd_err, any_gate);
      end
    end
    bus.motor_up = 1'b1;
    while (bus.running !== 1'b1 && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    n_checks++;
    if (bus.running !== 1'b1) begin
      n_fail++;
      $display("FAIL conflict_reach_run: got running=%b expected 1", bus.running);
    end
    bus.motor_dn = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.cmd_err !== 1'b1 || any_gate !== 1'b0 || bus.running !== 1'b0 || bus.duty !== '0) begin
      n_fail++;
      $display("FAIL conflict_run_err: got err=%b gates=%b run=%b duty=%0d expected 1 0 0 0",
               bus.cmd_err, any_gate, bus.running, bus.duty);
    end
    @(negedge clk);
    n_checks++;
    if (bus.cmd_err !== 1'b0 || any_gate !== 1'b0) begin
      n_fail++;
      $display("FAIL conflict_dead_quiet: got err=%b gates=%b expected 0 0", bus.cmd_err, any_gate);
    end
    go_idle();
  endtask

  task automatic test_reset_run();
    int waited = 0;
    @(negedge clk);
    bus.motor_dn = 1'b1;
    while (bus.running !== 1'b1 && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    n_checks++;
    if (bus.running !== 1'b1 || bus.hs_b !== 1'b1 || bus.ls_a !== 1'b1) begin
      n_fail++;
      $display("FAIL rstrun_reach_run: got run=%b hs_b=%b ls_a=%b expected 1 1 1",
               bus.running, bus.hs_b, bus.ls_a);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (dut_vec !== '0) begin
      n_fail++;
      $display("FAIL rstrun_async: got %b expected %b", dut_vec, {VW{1'b0}});
    end
    #49 rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.hs_b !== 1'b1 || bus.ls_a !== 1'b1 || bus.duty !== (PB+1)'(1) ||
        bus.running !== 1'b0 || dut_vec !== exp_vec()) begin
      n_fail++;
      $display("FAIL rstrun_restart: got %b expected %b", dut_vec, exp_vec());
    end
    go_idle();
  endtask

  task automatic test_random();
    int  off = 0;
    bit  seen = 1'b0;
    bit  prev_on = 1'b0;
    bit  on;
    logic [1:0] cmd;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      n_checks++;
      if (dut_vec !== exp_vec()) begin
        n_fail++;
        $display("FAIL rand_model cyc %0d: got %b expected %b", i, dut_vec, exp_vec());
      end
      n_checks++;
      if ((bus.hs_a & bus.ls_a) | (bus.hs_b & bus.ls_b) | (bus.hs_a & bus.hs_b) | (bus.ls_a & bus.ls_b)) begin
        n_fail++;
        $display("FAIL rand_shoot cyc %0d: got gates=%b%b%b%b expected no overlap",
                 i, bus.hs_a, bus.ls_a, bus.hs_b, bus.ls_b);
      end
      n_checks++;
      if ((m_mode == 0 || m_mode == 3) && any_gate !== 1'b0) begin
        n_fail++;
        $display("FAIL rand_off_state cyc %0d: got gates=%b expected 0", i, any_gate);
      end
      on = (any_gate === 1'b1);
      if (on && !prev_on) begin
        if (seen) begin
          n_checks++;
          if (off < DC + 1) begin
            n_fail++;
            $display("FAIL rand_gap cyc %0d: got %0d expected >= %0d", i, off, DC + 1);
          end
        end
        seen = 1'b1;
      end
      if (on) off = 0;
      else    off++;
      prev_on = on;
      if ($urandom_range(0, 29) == 0) begin
        cmd = 2'($urandom_range(0, 3));
        bus.motor_up = cmd[0];
        bus.motor_dn = cmd[1];
      end
    end
    go_idle();
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_up_run();
    test_stop();
    test_reversal();
    test_conflict();
    test_reset_run();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
